// File: rtl/battle_resolver.sv
// Multi-cycle combat resolver: alternates player/enemy strikes against a built-in enemy stat table.
// Optional macro BATTLE_ROUND_STEP_EN adds i_step to pace each round after the first.
module battle_resolver #(
   parameter int TILE_W     = 8,
   parameter int STAT_W     = 16,
   parameter int ROUND_W    = 8,
   parameter int MAX_ROUNDS = 255
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   input  logic [TILE_W-1:0]  i_tile_id,
   input  logic [STAT_W-1:0]  i_p_atk,
   input  logic [STAT_W-1:0]  i_p_def,
   input  logic [STAT_W-1:0]  i_p_hp,
`ifdef BATTLE_ROUND_STEP_EN
   input  logic               i_step,
`endif
   output logic               o_busy,
   output logic               o_done,
   output logic [2:0]         o_result,
   output logic [ROUND_W-1:0] o_rounds,
   output logic [STAT_W-1:0]  o_damage_taken,
   output logic [STAT_W-1:0]  o_enemy_hp_left
);

   // Enemy family base tile IDs; each family occupies 8 consecutive IDs.
   localparam logic [TILE_W-1:0] RS_SLIME    = TILE_W'(8'h10);
   localparam logic [TILE_W-1:0] RS_BAT      = TILE_W'(8'h18);
   localparam logic [TILE_W-1:0] RS_SKELETON = TILE_W'(8'h20);
   localparam logic [TILE_W-1:0] RS_MUMMY    = TILE_W'(8'h28);
   localparam logic [TILE_W-1:0] RS_WIZARD   = TILE_W'(8'h30);
   localparam logic [TILE_W-1:0] RS_KNIGHT   = TILE_W'(8'h38);

   localparam logic [2:0] RES_WIN        = 3'd0;
   localparam logic [2:0] RES_LOSE       = 3'd1;
   localparam logic [2:0] RES_CANNOT_WIN = 3'd2;
   localparam logic [2:0] RES_NOT_ENEMY  = 3'd3;
   localparam logic [2:0] RES_TIMEOUT    = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_PLAYER_HIT,
      S_ENEMY_HIT,
`ifdef BATTLE_ROUND_STEP_EN
      S_WAIT_STEP,
`endif
      S_DONE
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [TILE_W-1:0]  r_tile, w_tile_nxt;
   logic [STAT_W-1:0]  r_patk, w_patk_nxt, r_pdef, w_pdef_nxt, r_php, w_php_nxt;
   logic [STAT_W-1:0]  r_eatk, w_eatk_nxt, r_edef, w_edef_nxt, r_ehp, w_ehp_nxt;
   logic [STAT_W-1:0]  r_dmg, w_dmg_nxt;
   logic [ROUND_W-1:0] r_rounds, w_rounds_nxt;
   logic [2:0]         r_result, w_result_nxt;

   logic [2:0]          w_idx;
   logic [TILE_W-4:0]   w_fam;
   logic [STAT_W-1:0]   w_tab_atk, w_pdmg, w_edmg, w_dsat;
   logic [STAT_W:0]     w_dsum;
   logic                w_go_player;

   assign w_idx = r_tile[2:0];
   assign w_fam = r_tile[TILE_W-1:3];

   always_comb begin
      w_tab_atk = '0;
      if (w_fam == RS_SLIME[TILE_W-1:3])
         w_tab_atk = STAT_W'(w_idx[2:1]) + STAT_W'(1);
      else if (w_fam == RS_BAT[TILE_W-1:3])
         w_tab_atk = STAT_W'(w_idx[2:1]) + STAT_W'(2);
      else if (w_fam == RS_SKELETON[TILE_W-1:3])
         w_tab_atk = STAT_W'(w_idx[2:1]) + STAT_W'(3);
      else if (w_fam == RS_MUMMY[TILE_W-1:3] || w_fam == RS_WIZARD[TILE_W-1:3] ||
               w_fam == RS_KNIGHT[TILE_W-1:3])
         w_tab_atk = STAT_W'({w_idx[2:1], 1'b0}) + STAT_W'(4);
   end

   assign w_pdmg = (r_patk > r_edef) ? r_patk - r_edef : '0;
   assign w_edmg = (r_eatk > r_pdef) ? r_eatk - r_pdef : '0;
   assign w_dsum = {1'b0, r_dmg} + {1'b0, w_edmg};
   assign w_dsat = w_dsum[STAT_W] ? '1 : w_dsum[STAT_W-1:0];

`ifdef BATTLE_ROUND_STEP_EN
   assign w_go_player = i_step;
`else
   assign w_go_player = 1'b1;
`endif

   always_comb begin
      w_state_nxt  = r_state;
      w_tile_nxt   = r_tile;
      w_patk_nxt   = r_patk;
      w_pdef_nxt   = r_pdef;
      w_php_nxt    = r_php;
      w_eatk_nxt   = r_eatk;
      w_edef_nxt   = r_edef;
      w_ehp_nxt    = r_ehp;
      w_dmg_nxt    = r_dmg;
      w_rounds_nxt = r_rounds;
      w_result_nxt = r_result;
      case (r_state)
         S_IDLE: if (i_start) begin
            w_tile_nxt  = i_tile_id;
            w_patk_nxt  = i_p_atk;
            w_pdef_nxt  = i_p_def;
            w_php_nxt   = i_p_hp;
            w_state_nxt = S_LOAD;
         end
         S_LOAD: begin
            w_eatk_nxt   = w_tab_atk;
            w_edef_nxt   = w_tab_atk >> 1;
            w_ehp_nxt    = w_tab_atk << 3;
            w_rounds_nxt = '0;
            w_dmg_nxt    = '0;
            if (w_tab_atk == '0) begin
               w_result_nxt = RES_NOT_ENEMY;
               w_state_nxt  = S_DONE;
            end else begin
               w_state_nxt  = S_PLAYER_HIT;
            end
         end
         S_PLAYER_HIT: begin
            if (w_pdmg == '0) begin
               w_result_nxt = RES_CANNOT_WIN;
               w_state_nxt  = S_DONE;
            end else begin
               w_rounds_nxt = r_rounds + ROUND_W'(1);
               if (r_ehp <= w_pdmg) begin
                  w_ehp_nxt    = '0;
                  w_result_nxt = RES_WIN;
                  w_state_nxt  = S_DONE;
               end else begin
                  w_ehp_nxt    = r_ehp - w_pdmg;
                  w_state_nxt  = S_ENEMY_HIT;
               end
            end
         end
         S_ENEMY_HIT: begin
            w_dmg_nxt = w_dsat;
            if (w_dsat >= r_php) begin
               w_result_nxt = RES_LOSE;
               w_state_nxt  = S_DONE;
            end else if (r_rounds == ROUND_W'(MAX_ROUNDS)) begin
               w_result_nxt = RES_TIMEOUT;
               w_state_nxt  = S_DONE;
            end else if (w_go_player) begin
               w_state_nxt  = S_PLAYER_HIT;
            end else begin
`ifdef BATTLE_ROUND_STEP_EN
               w_state_nxt  = S_WAIT_STEP;
`else
               w_state_nxt  = S_PLAYER_HIT;
`endif
            end
         end
`ifdef BATTLE_ROUND_STEP_EN
         S_WAIT_STEP: if (i_step) w_state_nxt = S_PLAYER_HIT;
`endif
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= S_IDLE;
         r_tile   <= '0;
         r_patk   <= '0;
         r_pdef   <= '0;
         r_php    <= '0;
         r_eatk   <= '0;
         r_edef   <= '0;
         r_ehp    <= '0;
         r_dmg    <= '0;
         r_rounds <= '0;
         r_result <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_tile   <= w_tile_nxt;
         r_patk   <= w_patk_nxt;
         r_pdef   <= w_pdef_nxt;
         r_php    <= w_php_nxt;
         r_eatk   <= w_eatk_nxt;
         r_edef   <= w_edef_nxt;
         r_ehp    <= w_ehp_nxt;
         r_dmg    <= w_dmg_nxt;
         r_rounds <= w_rounds_nxt;
         r_result <= w_result_nxt;
      end
   end

   assign o_busy          = (r_state != S_IDLE);
   assign o_done          = (r_state == S_DONE);
   assign o_result        = r_result;
   assign o_rounds        = r_rounds;
   assign o_damage_taken  = r_dmg;
   assign o_enemy_hp_left = r_ehp;

endmodule

// File: tb/tb_battle_resolver.sv
// Table-driven bench for battle_resolver; second instance with MAX_ROUNDS=4 covers TIMEOUT.
module tb_battle_resolver;
   localparam logic [7:0] RS_SLIME = 8'h10, RS_BAT = 8'h18, RS_SKELETON = 8'h20;
   localparam logic [7:0] RS_MUMMY = 8'h28, RS_WIZARD = 8'h30, RS_KNIGHT = 8'h38;

   logic clk = 1'b0, rst, start, step;
   logic [7:0]  tile;
   logic [15:0] patk, pdef, php;
   logic        m_busy, m_done, t_busy, t_done;
   logic [2:0]  m_res, t_res;
   logic [7:0]  m_rnd, t_rnd;
   logic [15:0] m_dmg, m_ehp, t_dmg, t_ehp;

   int errors = 0, checks = 0;

   always #5 clk = ~clk;

   battle_resolver u_main (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_tile_id(tile),
      .i_p_atk(patk), .i_p_def(pdef), .i_p_hp(php),
`ifdef BATTLE_ROUND_STEP_EN
      .i_step(step),
`endif
      .o_busy(m_busy), .o_done(m_done), .o_result(m_res), .o_rounds(m_rnd),
      .o_damage_taken(m_dmg), .o_enemy_hp_left(m_ehp));

   battle_resolver #(.MAX_ROUNDS(4)) u_to (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_tile_id(tile),
      .i_p_atk(patk), .i_p_def(pdef), .i_p_hp(php),
`ifdef BATTLE_ROUND_STEP_EN
      .i_step(step),
`endif
      .o_busy(t_busy), .o_done(t_done), .o_result(t_res), .o_rounds(t_rnd),
      .o_damage_taken(t_dmg), .o_enemy_hp_left(t_ehp));

   typedef struct {
      logic [7:0]  tile;
      logic [15:0] atk, def, hp;
      logic        sel_to;
      logic [2:0]  res;
      logic [7:0]  rnd;
      logic [15:0] dmg, ehp;
      int          lat;
   } vec_t;

   vec_t exp_q[$];

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while ((m_busy || t_busy) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) chk("idle_timeout", 1, 0);
   endtask

   // poke: cycle at which a second start is pulsed; rst_at: cycle at which reset is asserted.
   task automatic run_vec(input vec_t v, input int poke, input int rst_at);
      vec_t e;
      int   k = 0;
      bit   got = 0, saw_done = 0;
      logic s_done, s_busy;
      logic [2:0] s_res;
      logic [7:0] s_rnd;
      logic [15:0] s_dmg, s_ehp;
      wait_idle();
      tile = v.tile; patk = v.atk; pdef = v.def; php = v.hp; start = 1'b1;
      exp_q.push_back(v);
      @(posedge clk);
      #1 start = 1'b0;
      while (k < 600 && !got) begin
         @(negedge clk);
         k++;
         start = 1'b0;
         if (k == poke) begin
            tile = RS_KNIGHT + 8'd7; patk = 16'd1; pdef = 16'd0; php = 16'd1; start = 1'b1;
         end
         s_done = v.sel_to ? t_done : m_done;
         s_busy = v.sel_to ? t_busy : m_busy;
         if (k == 1) chk("busy_after_start", s_busy, 1);
         if (k == rst_at + 1 && rst_at != 0) begin
            rst = 1'b0;
            chk("rst_busy", m_busy, 0);
            chk("rst_done", m_done, 0);
            chk("rst_result", m_res, 0);
            chk("rst_rounds", m_rnd, 0);
            chk("rst_dmg", m_dmg, 0);
            chk("rst_ehp", m_ehp, 0);
            repeat (10) begin
               @(negedge clk);
               if (m_done) saw_done = 1;
            end
            chk("rst_no_done", saw_done, 0);
            void'(exp_q.pop_front());
            return;
         end
         if (k == rst_at && rst_at != 0) rst = 1'b1;
         if (s_done) begin
            got = 1;
            e = exp_q.pop_front();
            s_res = v.sel_to ? t_res : m_res;
            s_rnd = v.sel_to ? t_rnd : m_rnd;
            s_dmg = v.sel_to ? t_dmg : m_dmg;
            s_ehp = v.sel_to ? t_ehp : m_ehp;
            chk("result", s_res, e.res);
            chk("rounds", s_rnd, e.rnd);
            chk("damage_taken", s_dmg, e.dmg);
            chk("enemy_hp_left", s_ehp, e.ehp);
            chk("latency", k, e.lat);
         end
      end
      if (!got) begin
         chk("done_timeout", 0, 1);
         void'(exp_q.pop_front());
         return;
      end
      @(negedge clk);
      start = 1'b0;
      chk("done_one_cycle", v.sel_to ? t_done : m_done, 0);
      chk("busy_after_done", v.sel_to ? t_busy : m_busy, 0);
      chk("result_hold", v.sel_to ? t_res : m_res, v.res);
   endtask

   vec_t tbl[14];

   initial begin
      //           tile             atk  def  hp  to  res  rnd  dmg  ehp  lat
      tbl[0]  = '{RS_SLIME+0,       3,   0,  10, 0, 3'd0, 3,  2,   0,   7};
      tbl[1]  = '{RS_KNIGHT+6,      6,   0,  15, 0, 3'd1, 2,  20,  78,  6};
      tbl[2]  = '{RS_KNIGHT+6,      2,   0,  15, 0, 3'd2, 0,  0,   80,  3};
      tbl[3]  = '{8'h40,            5,   0,  10, 0, 3'd3, 0,  0,   0,   2};
      tbl[4]  = '{8'h00,            5,   0,  10, 0, 3'd3, 0,  0,   0,   2};
      tbl[5]  = '{RS_SLIME+0,       1,   5,  10, 1, 3'd4, 4,  0,   4,   10};
      tbl[6]  = '{RS_BAT+7,         10,  1, 100, 0, 3'd0, 5,  16,  0,   11};
      tbl[7]  = '{RS_SLIME+0,       3,   0,   0, 0, 3'd1, 1,  1,   5,   4};
      tbl[8]  = '{RS_WIZARD+1,      10,  0,  50, 0, 3'd0, 4,  12,  0,   9};
      tbl[9]  = '{RS_SKELETON+3,    2,   0,  50, 0, 3'd2, 0,  0,   32,  3};
      tbl[10] = '{RS_MUMMY+7,       45,  3,   7, 0, 3'd1, 1,  7,   40,  4};
      tbl[11] = '{RS_SKELETON+0,    25,  0,   5, 0, 3'd0, 1,  0,   0,   3};
      tbl[12] = '{RS_BAT+0,         1,   0,   5, 0, 3'd2, 0,  0,   16,  3};
      tbl[13] = '{RS_SLIME+7,       10,  4,   1, 0, 3'd0, 4,  0,   0,   9};

      rst = 1'b1; start = 1'b0; step = 1'b1; tile = '0; patk = '0; pdef = '0; php = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_busy", m_busy, 0);
      chk("reset_done", m_done, 0);
      chk("reset_result", m_res, 0);
      chk("reset_rounds", m_rnd, 0);
      chk("reset_dmg", m_dmg, 0);
      chk("reset_ehp", m_ehp, 0);
      rst = 1'b0;

      foreach (tbl[i]) run_vec(tbl[i], 0, 0);

      // second start while busy, and while in DONE, must be ignored
      run_vec(tbl[0], 2, 0);
      run_vec(tbl[0], 7, 0);
      // reset mid-battle aborts without a done pulse; a new battle then completes
      run_vec(tbl[1], 0, 4);
      run_vec(tbl[1], 0, 0);

`ifdef BATTLE_ROUND_STEP_EN
      begin
         int k = 0;
         bit got = 0;
         wait_idle();
         tile = RS_SLIME; patk = 16'd3; pdef = 16'd0; php = 16'd10; step = 1'b0; start = 1'b1;
         @(posedge clk);
         #1 start = 1'b0;
         while (k < 100 && !got) begin
            @(negedge clk);
            k++;
            step = (k == 8 || k == 15);
            if (m_done) begin
               got = 1;
               chk("step_latency", k, 17);
               chk("step_result", m_res, 0);
               chk("step_rounds", m_rnd, 3);
               chk("step_dmg", m_dmg, 2);
               chk("step_ehp", m_ehp, 0);
            end
         end
         if (!got) chk("step_done_timeout", 0, 1);
         step = 1'b1;
      end
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/battle_resolver.md
Name: battle_resolver

Overview:
Multi-cycle combat resolver: given an enemy tile ID and the player's attack, defence and HP, it simulates alternating rounds and reports the outcome, damage taken and rounds fought. Successor to the combinational per-tile attack lookup, with these changes:
- Tile ID width is parameterised and the stat width is generic.
- Holds a full enemy stat table (hp/atk/def) indexed by the RS_ tile constants from the resources parameter include.
- Sits between the interact logic and the player-stat registers; started once per bump into an enemy tile.

Parameters:
TILE_W, 8, width of tile_id
STAT_W, 16, width of all HP/attack/defence/damage values
ROUND_W, 8, width of round counter
MAX_ROUNDS, 255, round limit before TIMEOUT (1..2^ROUND_W-1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle request; accepted only in IDLE
tile_id  in  TILE_W  enemy tile ID, sampled on accepted start
p_atk  in  STAT_W  player attack, sampled on accepted start
p_def  in  STAT_W  player defence, sampled on accepted start
p_hp  in  STAT_W  player current HP, sampled on accepted start
busy  out  1  high from cycle after accepted start until DONE exits
done  out  1  one-cycle pulse when result valid
result  out  3  0 WIN, 1 LOSE, 2 CANNOT_WIN, 3 NOT_ENEMY, 4 TIMEOUT
rounds  out  ROUND_W  player strikes performed
damage_taken  out  STAT_W  total enemy damage dealt to player (saturating)
enemy_hp_left  out  STAT_W  enemy HP remaining at end

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Reset returns the block to IDLE and clears busy, done, result, rounds, damage_taken and enemy_hp_left to 0. Reset mid-battle aborts the battle with no done pulse.
- Stat table, per enemy family, index 0..7:
  - slime atk 1,1,2,2,3,3,4,4
  - bat atk 2,2,3,3,4,4,5,5
  - skeleton atk 3,3,4,4,5,5,6,6
  - mummy, wizard and knight atk 4,4,6,6,8,8,10,10
  - For every enemy: hp = 8*atk, def = atk>>1.
  - Any other tile ID gives hp=atk=def=0 (not an enemy).
- FSM states: IDLE, LOAD, PLAYER_HIT, ENEMY_HIT, DONE.
- IDLE:
  - On start, latch all inputs and go to LOAD.
  - start while busy, or in DONE, is ignored.
- LOAD (1 cycle):
  - Register the table lookup; clear rounds and damage_taken.
  - If hp==0, go to DONE with NOT_ENEMY, enemy_hp_left=0.
  - Otherwise go to PLAYER_HIT.
- PLAYER_HIT:
  - dmg = (p_atk > e_def) ? p_atk - e_def : 0.
  - If dmg==0, go to DONE with CANNOT_WIN; rounds unchanged.
  - Otherwise rounds++ and e_hp = (e_hp <= dmg) ? 0 : e_hp - dmg.
  - If e_hp becomes 0, go to DONE with WIN (the enemy does not strike back).
  - Otherwise go to ENEMY_HIT.
- ENEMY_HIT:
  - edmg = (e_atk > p_def) ? e_atk - p_def : 0.
  - damage_taken += edmg, saturating at 2^STAT_W-1.
  - If damage_taken >= p_hp, go to DONE with LOSE.
  - Else if rounds == MAX_ROUNDS, go to DONE with TIMEOUT.
  - Else go to PLAYER_HIT.
- DONE: assert done for exactly 1 cycle, then go to IDLE. result, rounds, damage_taken and enemy_hp_left hold until the next accepted start.
- Latency, with start accepted at edge T (R = rounds):
  - NOT_ENEMY: done at T+2.
  - CANNOT_WIN: done at T+3.
  - WIN: done at T+2R+1.
  - LOSE or TIMEOUT: done at T+2R+2.
- p_hp==0 at start: the player strikes first, and the first ENEMY_HIT always gives LOSE (0 >= 0).

Optional Feature:
BATTLE_ROUND_STEP_EN.
- Defined:
  - Adds input port `step` (1 bit).
  - A WAIT_STEP state is inserted before every PLAYER_HIT except the first; it waits until step==1, so the display can animate one round per step.
  - busy stays high while waiting.
  - Reset clears the wait.
  - Latencies above grow by the number of wait cycles.
- Undefined: no step port, and timing is exactly as specified above.

Test Plan:
- slime_0 (hp8 atk1 def0); p_atk=3 p_def=0 p_hp=10 -> WIN, rounds=3, damage_taken=2, enemy_hp_left=0, done at T+7.
- knight_6 (hp80 atk10 def5); p_atk=6 p_def=0 p_hp=15 -> LOSE, rounds=2, damage_taken=20, enemy_hp_left=78, done at T+6.
- knight_6; p_atk=2 -> CANNOT_WIN, rounds=0, damage_taken=0, done at T+3. Non-enemy tile ID -> NOT_ENEMY, done at T+2.
- MAX_ROUNDS=4, slime_0; p_atk=1 p_def=5 p_hp=10 -> TIMEOUT, rounds=4, damage_taken=0, enemy_hp_left=4, done at T+10.
- start pulsed again while busy -> ignored, first result unchanged. rst asserted at T+4 of a battle -> busy=0 next cycle, all outputs 0, no done pulse. A new start then completes normally.
- With BATTLE_ROUND_STEP_EN on the slime_0 WIN case: hold step low 5 cycles before each later round -> done at T+17, same result values.
